move_log_fifo: RTL and testbench

MOVE_LOG_FIFO -- requirements
Module: move_log_fifo

---
 rtl/chess_pkg.sv | 38 +++
 rtl/sync_fifo.sv | 89 ++++++++
 rtl/move_log_fifo.sv | 107 ++++++++++
 tb/tb_move_log_fifo.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/chess_pkg.sv
// Shared chess definitions: piece and color codes, square address width,
// the move record layout and the pairer FSM states.
package chess_pkg;

    localparam int ADDR_W  = 6;
    localparam int PIECE_W = 4;
    localparam int REC_W   = 1 + 2 * (ADDR_W + PIECE_W);

    typedef enum logic [2:0] {
        PIECE_NONE   = 3'd0,
        PIECE_PAWN   = 3'd1,
        PIECE_KNIGHT = 3'd2,
        PIECE_BISHOP = 3'd3,
        PIECE_ROOK   = 3'd4,
        PIECE_QUEEN  = 3'd5,
        PIECE_KING   = 3'd6
    } piece_t;

    typedef enum logic {
        COLOR_WHITE = 1'b0,
        COLOR_BLACK = 1'b1
    } color_t;

    // One logged move: two square writes, or one write that never found a partner.
    typedef struct packed {
        logic               single;
        logic [ADDR_W-1:0]  addr0;
        logic [PIECE_W-1:0] piece0;
        logic [ADDR_W-1:0]  addr1;
        logic [PIECE_W-1:0] piece1;
    } move_rec_t;

    typedef enum logic {
        IDLE = 1'b0,
        HALF = 1'b1
    } pair_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered head word, sticky drop flag and
// synchronous clear. The head register makes the output resettable even
// though the storage array is not.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 21
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop_ready,
    output logic                     pop_valid,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_q, wr_q, rd_next;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] head_q;
    logic             overflow_q;
    logic             full, do_pop, do_push, drop;

    assign full     = (count_q == CW'(DEPTH));
    assign do_pop   = (count_q != '0) && pop_ready;
    assign do_push  = push && (!full || do_pop);
    assign drop     = push && full && !do_pop;
    assign rd_next  = rd_q + 1'b1;

    assign pop_valid = (count_q != '0);
    assign pop_data  = head_q;
    assign count     = count_q;
    assign overflow  = overflow_q;

    // Storage array write; contents are don't-care until pointed at.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_q] <= push_data;
        end
    end

    // Pointers, occupancy, head word and sticky drop flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q       <= '0;
            wr_q       <= '0;
            count_q    <= '0;
            head_q     <= '0;
            overflow_q <= 1'b0;
        end else if (clear) begin
            rd_q       <= '0;
            wr_q       <= '0;
            count_q    <= '0;
            head_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_push) begin
                wr_q <= wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_q <= rd_next;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
            if (do_pop) begin
                if (count_q > CW'(1)) begin
                    head_q <= mem[rd_next];
                end else if (do_push) begin
                    head_q <= push_data;
                end
            end else if (do_push && count_q == '0) begin
                head_q <= push_data;
            end
        end
    end

endmodule

// File: rtl/move_log_fifo.sv
// Pairs consecutive board square writes into move records and queues them.
// A lone write that waits too long is logged as a single-square record.
module move_log_fifo
    import chess_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int PAIR_TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    init,
    input  logic                    chg_en,
    input  logic [5:0]              chg_addr,
    input  logic [3:0]              chg_piece,
    output logic                    rec_valid,
    input  logic                    rec_ready,
    output logic [20:0]             rec_data,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow
);

    localparam int TIMER_W = (PAIR_TIMEOUT < 2) ? 1 : $clog2(PAIR_TIMEOUT);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(PAIR_TIMEOUT - 1);

    pair_state_t          state_q, state_d;
    logic [ADDR_W-1:0]    addr0_q, addr0_d;
    logic [PIECE_W-1:0]   piece0_q, piece0_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic                 push;
    move_rec_t            push_rec;

    // Pairer state, latched first half and wait timer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            addr0_q  <= '0;
            piece0_q <= '0;
            timer_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr0_q  <= addr0_d;
            piece0_q <= piece0_d;
            timer_q  <= timer_d;
        end
    end

    // Next state and record formation; a partner write beats the timeout.
    always_comb begin
        state_d  = state_q;
        addr0_d  = addr0_q;
        piece0_d = piece0_q;
        timer_d  = timer_q;
        push     = 1'b0;
        push_rec = '0;
        if (init) begin
            state_d = IDLE;
            timer_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (chg_en) begin
                        addr0_d  = chg_addr;
                        piece0_d = chg_piece;
                        timer_d  = '0;
                        state_d  = HALF;
                    end
                end
                HALF: begin
                    push_rec.addr0  = addr0_q;
                    push_rec.piece0 = piece0_q;
                    if (chg_en) begin
                        push            = 1'b1;
                        push_rec.addr1  = chg_addr;
                        push_rec.piece1 = chg_piece;
                        timer_d         = '0;
                        state_d         = IDLE;
                    end else if (timer_q == TIMER_LAST) begin
                        push            = 1'b1;
                        push_rec.single = 1'b1;
                        timer_d         = '0;
                        state_d         = IDLE;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REC_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (init),
        .push      (push),
        .push_data (push_rec),
        .pop_ready (rec_ready),
        .pop_valid (rec_valid),
        .pop_data  (rec_data),
        .count     (count),
        .overflow  (overflow)
    );

endmodule

// File: tb/tb_move_log_fifo.sv
// Directed bench for move_log_fifo with DEPTH=16 and PAIR_TIMEOUT=255.
module tb_move_log_fifo;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        init = 1'b0;
    logic        chg_en = 1'b0;
    logic [5:0]  chg_addr = '0;
    logic [3:0]  chg_piece = '0;
    logic        rec_valid;
    logic        rec_ready = 1'b0;
    logic [20:0] rec_data;
    logic [4:0]  count;
    logic        overflow;

    int checks = 0;
    int failures = 0;

    move_log_fifo #(
        .DEPTH        (16),
        .PAIR_TIMEOUT (255)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .init      (init),
        .chg_en    (chg_en),
        .chg_addr  (chg_addr),
        .chg_piece (chg_piece),
        .rec_valid (rec_valid),
        .rec_ready (rec_ready),
        .rec_data  (rec_data),
        .count     (count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Expected pair record for the i-th pair in the fill sequences.
    function automatic logic [20:0] rec(input int i);
        return {1'b0, 6'(i), 4'(i), 6'(i + 32), 4'(15 - i)};
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [5:0] a, input logic [3:0] p);
        chg_en    = 1'b1;
        chg_addr  = a;
        chg_piece = p;
        cycle();
        chg_en = 1'b0;
    endtask

    task automatic write_pair(input int i);
        write(6'(i), 4'(i));
        write(6'(i + 32), 4'(15 - i));
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        checks++;
        if (rec_valid !== 1'b0 || count !== 5'd0 || rec_data !== 21'd0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: got valid=%b count=%0d data=%h ovf=%b required 0/0/0/0",
                     rec_valid, count, rec_data, overflow);
        end
        #1 rst_n = 1'b1;
        cycle();
    endtask

    task automatic test_pair();
        write(6'h34, 4'h9);
        checks++;
        if (rec_valid !== 1'b0) begin
            failures++;
            $display("FAIL pair_half_no_valid: got %b required 0", rec_valid);
        end
        write(6'h24, 4'h0);
        checks++;
        if (rec_valid !== 1'b1 || count !== 5'd1) begin
            failures++;
            $display("FAIL pair_valid: got valid=%b count=%0d required 1/1", rec_valid, count);
        end
        checks++;
        if (rec_data !== {1'b0, 6'h34, 4'h9, 6'h24, 4'h0}) begin
            failures++;
            $display("FAIL pair_data: got %h required %h", rec_data, {1'b0, 6'h34, 4'h9, 6'h24, 4'h0});
        end
        rec_ready = 1'b1;
        cycle();
        rec_ready = 1'b0;
        checks++;
        if (rec_valid !== 1'b0 || count !== 5'd0) begin
            failures++;
            $display("FAIL pair_pop: got valid=%b count=%0d required 0/0", rec_valid, count);
        end
    endtask

    task automatic test_timeout();
        write(6'h01, 4'h2);
        repeat (254) cycle();
        checks++;
        if (count !== 5'd0) begin
            failures++;
            $display("FAIL timeout_early: got count=%0d required 0", count);
        end
        cycle();
        checks++;
        if (count !== 5'd1 || rec_data !== {1'b1, 6'h01, 4'h2, 10'd0}) begin
            failures++;
            $display("FAIL timeout_single: got count=%0d data=%h required 1/%h",
                     count, rec_data, {1'b1, 6'h01, 4'h2, 10'd0});
        end
        rec_ready = 1'b1;
        cycle();
        rec_ready = 1'b0;
        write(6'h01, 4'h2);
        repeat (254) cycle();
        write(6'h05, 4'h3);
        checks++;
        if (count !== 5'd1 || rec_data !== {1'b0, 6'h01, 4'h2, 6'h05, 4'h3}) begin
            failures++;
            $display("FAIL timeout_pair_wins: got count=%0d data=%h required 1/%h",
                     count, rec_data, {1'b0, 6'h01, 4'h2, 6'h05, 4'h3});
        end
        rec_ready = 1'b1;
        cycle();
        rec_ready = 1'b0;
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 17; i++) write_pair(i);
        checks++;
        if (count !== 5'd16 || overflow !== 1'b1 || rec_data !== rec(0)) begin
            failures++;
            $display("FAIL overflow_full: got count=%0d ovf=%b head=%h required 16/1/%h",
                     count, overflow, rec_data, rec(0));
        end
        rec_ready = 1'b1;
        for (int j = 0; j < 16; j++) begin
            checks++;
            if (rec_valid !== 1'b1 || rec_data !== rec(j)) begin
                failures++;
                $display("FAIL overflow_drain_%0d: got valid=%b data=%h required 1/%h",
                         j, rec_valid, rec_data, rec(j));
            end
            cycle();
        end
        rec_ready = 1'b0;
        checks++;
        if (rec_valid !== 1'b0 || count !== 5'd0 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL overflow_empty: got valid=%b count=%0d ovf=%b required 0/0/1",
                     rec_valid, count, overflow);
        end
    endtask

    task automatic test_back_to_back();
        init = 1'b1;
        cycle();
        init = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL b2b_ovf_clear: got %b required 0", overflow);
        end
        for (int i = 0; i < 16; i++) write_pair(i);
        write(6'(16), 4'(16));
        rec_ready = 1'b1;
        write(6'(48), 4'(15 - 16));
        rec_ready = 1'b0;
        checks++;
        if (count !== 5'd16 || overflow !== 1'b0 || rec_data !== rec(1)) begin
            failures++;
            $display("FAIL b2b_full_pushpop: got count=%0d ovf=%b head=%h required 16/0/%h",
                     count, overflow, rec_data, rec(1));
        end
        rec_ready = 1'b1;
        for (int j = 1; j <= 16; j++) begin
            checks++;
            if (rec_data !== rec(j)) begin
                failures++;
                $display("FAIL b2b_drain_%0d: got %h required %h", j, rec_data, rec(j));
            end
            cycle();
        end
        rec_ready = 1'b0;
        checks++;
        if (count !== 5'd0) begin
            failures++;
            $display("FAIL b2b_empty: got count=%0d required 0", count);
        end
    endtask

    task automatic test_init();
        for (int i = 0; i < 17; i++) write_pair(i);
        rec_ready = 1'b1;
        repeat (11) cycle();
        rec_ready = 1'b0;
        checks++;
        if (count !== 5'd5 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL init_setup: got count=%0d ovf=%b required 5/1", count, overflow);
        end
        write(6'h2A, 4'h7);
        init      = 1'b1;
        chg_en    = 1'b1;
        chg_addr  = 6'h3F;
        chg_piece = 4'hF;
        cycle();
        init   = 1'b0;
        chg_en = 1'b0;
        checks++;
        if (count !== 5'd0 || rec_valid !== 1'b0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL init_clear: got count=%0d valid=%b ovf=%b required 0/0/0",
                     count, rec_valid, overflow);
        end
        write(6'h10, 4'h1);
        checks++;
        if (count !== 5'd0) begin
            failures++;
            $display("FAIL init_fresh_half: got count=%0d required 0", count);
        end
        write(6'h11, 4'h2);
        checks++;
        if (count !== 5'd1 || rec_data !== {1'b0, 6'h10, 4'h1, 6'h11, 4'h2}) begin
            failures++;
            $display("FAIL init_fresh_pair: got count=%0d data=%h required 1/%h",
                     count, rec_data, {1'b0, 6'h10, 4'h1, 6'h11, 4'h2});
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) write_pair(i);
        rec_ready = 1'b1;
        write(6'h0C, 4'h4);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (count !== 5'd0 || rec_valid !== 1'b0 || rec_data !== 21'd0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_async: got count=%0d valid=%b data=%h ovf=%b required 0/0/0/0",
                     count, rec_valid, rec_data, overflow);
        end
        rec_ready = 1'b0;
        #1 rst_n = 1'b1;
        cycle();
        write(6'h22, 4'h5);
        checks++;
        if (count !== 5'd0) begin
            failures++;
            $display("FAIL reset_new_half: got count=%0d required 0", count);
        end
        write(6'h23, 4'h6);
        checks++;
        if (count !== 5'd1 || rec_data !== {1'b0, 6'h22, 4'h5, 6'h23, 4'h6}) begin
            failures++;
            $display("FAIL reset_new_pair: got count=%0d data=%h required 1/%h",
                     count, rec_data, {1'b0, 6'h22, 4'h5, 6'h23, 4'h6});
        end
    endtask

    initial begin
        test_reset();
        test_pair();
        test_timeout();
        test_overflow();
        test_back_to_back();
        test_init();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
